// File: rtl/wasm_run_monitor.sv
// Run monitor for a WASM core: times one program run in clock cycles,
// counts per-channel events while running, and reports how the run ended
// (finished, timed out or faulted). All counters saturate, never wrap.

// One event channel: a saturating counter cleared at run start.
module wasm_evt_lane #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Flags an increment that is dropped because the counter is already full.
  assign ovf = inc && (cnt == CNT_MAX);

  // Counter: cleared on run start, saturating increment otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (inc && !ovf)   cnt <= cnt + 1'b1;
  end
endmodule

module wasm_run_monitor #(
  parameter int CNT_W   = 32,
  parameter int N_EVT   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_finish,
  input  logic                   i_error,
  input  logic                   i_clear,
  input  logic [N_EVT-1:0]       i_evt,
  output logic [2:0]             o_state,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [CNT_W-1:0]       o_cycle_cnt,
  output logic [N_EVT*CNT_W-1:0] o_evt_cnt,
  output logic                   o_sat
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DONE  = 3'd2,
    TMO   = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // A limit that does not fit in the counter can never be reached, so the
  // watchdog is simply left off in that case.
  localparam bit               TMO_EN  = (TIMEOUT != 0) && ($clog2(TIMEOUT + 1) <= CNT_W);
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);

  state_t                       state;
  logic [CNT_W-1:0]             cycle_cnt;
  logic [N_EVT-1:0][CNT_W-1:0]  evt_cnt;
  logic [N_EVT-1:0]             evt_inc;
  logic [N_EVT-1:0]             evt_ovf;
  logic                         start_ok;
  logic                         run_live;
  logic                         tmo_hit;

  // Run-start and live-run qualifiers shared by all counters. A clear in RUN
  // freezes everything, so events on that edge are not counted.
  always_comb begin
    start_ok = (state == IDLE) && i_start && !i_clear;
    run_live = (state == RUN) && !i_clear;
    tmo_hit  = TMO_EN && (cycle_cnt == TMO_LIM);
    evt_inc  = run_live ? i_evt : '0;
  end

  genvar k;
  generate
    for (k = 0; k < N_EVT; k++) begin : g_lane
      wasm_evt_lane #(.CNT_W(CNT_W)) u_lane (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (start_ok),
        .inc   (evt_inc[k]),
        .cnt   (evt_cnt[k]),
        .ovf   (evt_ovf[k])
      );
    end
  endgenerate

  // Run FSM with cycle counter, sticky saturation flag and registered flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      o_sat     <= 1'b0;
      o_done    <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (|evt_ovf) o_sat <= 1'b1;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state     <= RUN;
            cycle_cnt <= '0;
            o_sat     <= 1'b0;
            o_busy    <= 1'b1;
          end
        end
        RUN: begin
          if (i_clear) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (i_error) begin
            state  <= FAULT;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end else if (i_finish) begin
            state  <= DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end else if (tmo_hit) begin
            state  <= TMO;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end else if (cycle_cnt == CNT_MAX) begin
            o_sat <= 1'b1;
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end
        DONE, TMO, FAULT: begin
          if (i_clear) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_state     = state;
  assign o_cycle_cnt = cycle_cnt;
  assign o_evt_cnt   = evt_cnt;
endmodule
